// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder: mnemonic + fields -> 32-bit word, behind a small FIFO.
// Optional saturating statistics counters when MIPS_ENC_STATS_EN is defined.
module mips_instr_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic              illegal
`ifdef MIPS_ENC_STATS_EN
    ,
    output logic [CNT_W-1:0]  enc_count,
    output logic [CNT_W-1:0]  illegal_count
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   enc;
    logic          legal;
    logic          accept;
    logic          push;
    logic          pop;

    assign in_ready  = (count != (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign instr     = mem[rd_ptr];
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;

    // Fields the ISA leaves unused for a mnemonic are forced to zero.
    always_comb begin
        enc   = '0;
        legal = 1'b1;
        case (mnem)
            5'd0:  enc = {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
            5'd1:  enc = {6'b000000, rs, rt, rd, 5'd0, 6'b100010};
            5'd2:  enc = {6'b000000, rs, rt, rd, 5'd0, 6'b100100};
            5'd3:  enc = {6'b000000, rs, rt, rd, 5'd0, 6'b100101};
            5'd4:  enc = {6'b000000, rs, rt, rd, 5'd0, 6'b101010};
            5'd5:  enc = {6'b000000, rs, 15'd0, 6'b001000};
            5'd6:  enc = {6'b000000, rs, 5'd0, rd, 5'd0, 6'b001001};
            5'd7:  enc = {6'b000000, rs, rt, 10'd0, 6'b011000};
            5'd8:  enc = {6'b100011, rs, rt, imm};
            5'd9:  enc = {6'b101011, rs, rt, imm};
            5'd10: enc = {6'b000100, rs, rt, imm};
            5'd11: enc = {6'b001000, rs, rt, imm};
            5'd12: enc = {6'b001001, rs, rt, imm};
            5'd13: enc = {6'b001101, rs, rt, imm};
            5'd14: enc = {6'b000010, target};
            5'd15: enc = {6'b000101, rs, rt, imm};
            5'd16: enc = {6'b100001, rs, rt, imm};
            5'd17: enc = {6'b100000, rs, rt, imm};
            5'd18: enc = {6'b100100, rs, rt, imm};
            5'd19: enc = {6'b001100, rs, rt, imm};
            5'd20: enc = {6'b000011, target};
            5'd21: enc = {6'b001111, 5'd0, rt, imm};
            5'd22: enc = {6'b001110, rs, rt, imm};
            5'd23: enc = {6'b000110, rs, 5'd0, imm};
            5'd24: enc = {6'b001010, rs, rt, imm};
            5'd25: enc = {6'b001011, rs, rt, imm};
            5'd26: enc = {6'b000111, rs, 5'd0, imm};
            5'd27: enc = {6'b100101, rs, rt, imm};
            5'd28: enc = {6'b101001, rs, rt, imm};
            5'd29: enc = {6'b101000, rs, rt, imm};
            default: legal = 1'b0;
        endcase
    end

    // Storage is cleared on reset so instr reads zero until the first write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            illegal <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= enc;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count   <= count + (AW+1)'(push) - (AW+1)'(pop);
            illegal <= accept && !legal;
        end
    end

`ifdef MIPS_ENC_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            enc_count     <= '0;
            illegal_count <= '0;
        end else begin
            if (push && (enc_count != '1)) begin
                enc_count <= enc_count + CNT_W'(1);
            end
            if (accept && !legal && (illegal_count != '1)) begin
                illegal_count <= illegal_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: directed plan vectors plus random
// traffic against a table-driven reference encoder.
module tb_mips_instr_encoder;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        illegal;
`ifdef MIPS_ENC_STATS_EN
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] illegal_count;
`endif

    mips_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mnem(mnem),
        .rs(rs),
        .rt(rt),
        .rd(rd),
        .shamt(shamt),
        .imm(imm),
        .target(target),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .instr(instr),
        .illegal(illegal)
`ifdef MIPS_ENC_STATS_EN
        ,
        .enc_count(enc_count),
        .illegal_count(illegal_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    bit          exp_ill = 1'b0;
    bit          rnd_ready = 1'b0;
    bit          cur_use = 1'b0;
    logic [31:0] cur_exp = '0;
    int          exp_enc_cnt = 0;
    int          exp_ill_cnt = 0;
    bit          stalled = 1'b0;
    logic [31:0] stall_word = '0;

    logic [5:0] op_tab [0:29];
    logic [5:0] fn_tab [0:7];

    task automatic chk(input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void ref_enc(input int m, input logic [4:0] a,
                                    input logic [4:0] b, input logic [4:0] c,
                                    input logic [4:0] s, input logic [15:0] im,
                                    input logic [25:0] tg, output bit ok,
                                    output logic [31:0] w);
        logic [4:0] xs;
        logic [4:0] xt;
        logic [4:0] xd;
        logic [4:0] xh;
        xs = a;
        xt = b;
        xd = c;
        xh = s;
        ok = (m < 30);
        w  = '0;
        if (!ok) return;
        if (m <= 7) begin
            if (m < 5) xh = '0;
            if (m == 5) begin xt = '0; xd = '0; xh = '0; end
            if (m == 6) begin xt = '0; xh = '0; end
            if (m == 7) begin xd = '0; xh = '0; end
            w = {6'b000000, xs, xt, xd, xh, fn_tab[m]};
        end else if (m == 14 || m == 20) begin
            w = {op_tab[m], tg};
        end else begin
            if (m == 21) xs = '0;
            if (m == 23 || m == 26) xt = '0;
            w = {op_tab[m], xs, xt, im};
        end
    endfunction

    // Driver-side: decides acceptance just before the edge and pushes the expectation.
    task automatic step(output bit acc);
        bit          ok;
        logic [31:0] w;
        @(negedge clk);
        #2;
        acc = !reset && in_valid && in_ready;
        if (acc) begin
            ref_enc(int'(mnem), rs, rt, rd, shamt, imm, target, ok, w);
            if (ok) begin
                q.push_back(cur_use ? cur_exp : w);
                exp_enc_cnt++;
            end else begin
                exp_ill_cnt++;
            end
            exp_ill = !ok;
        end else begin
            exp_ill = 1'b0;
        end
        if (reset) begin
            q.delete();
            exp_enc_cnt = 0;
            exp_ill_cnt = 0;
        end
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic set_in(input int m, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] c, input logic [4:0] s,
                          input logic [15:0] im, input logic [25:0] tg,
                          input bit use_exp, input logic [31:0] ew);
        in_valid = 1'b1;
        mnem     = m[4:0];
        rs       = a;
        rt       = b;
        rd       = c;
        shamt    = s;
        imm      = im;
        target   = tg;
        cur_use  = use_exp;
        cur_exp  = ew;
    endtask

    task automatic send(input int m, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [4:0] s,
                        input logic [15:0] im, input logic [25:0] tg,
                        input bit use_exp, input logic [31:0] ew);
        bit got;
        int n;
        got = 1'b0;
        n   = 0;
        set_in(m, a, b, c, s, im, tg, use_exp, ew);
        while (!got && n < 200) begin
            step(got);
            n++;
        end
        if (!got) chk(1'b0, "accept_timeout", 32'(n), 32'd200);
    endtask

    task automatic idle(input int n);
        bit g;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step(g);
    endtask

    task automatic drain();
        bit g;
        int n;
        n = 0;
        in_valid  = 1'b0;
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 50) begin
            step(g);
            n++;
        end
        chk(q.size() == 0, "drain_timeout", 32'(q.size()), 32'd0);
        step(g);
    endtask

    // Monitor: checks handshake state and pops the scoreboard on each dequeue.
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            chk(in_ready == (q.size() < DEPTH), "in_ready", 32'(in_ready),
                32'(q.size() < DEPTH));
            chk(out_valid == (q.size() != 0), "out_valid", 32'(out_valid),
                32'(q.size() != 0));
            chk(illegal == exp_ill, "illegal", 32'(illegal), 32'(exp_ill));
            if (stalled) chk(instr == stall_word, "stable", instr, stall_word);
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk(1'b0, "unexpected_word", instr, 32'd0);
                else begin
                    logic [31:0] e;
                    e = q.pop_front();
                    chk(instr == e, "instr", instr, e);
                end
            end
            stalled    = out_valid && !out_ready;
            stall_word = instr;
        end
    end

    initial begin
        bit g;
        op_tab = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                   6'b000000, 6'b000000, 6'b000000, 6'b100011, 6'b101011,
                   6'b000100, 6'b001000, 6'b001001, 6'b001101, 6'b000010,
                   6'b000101, 6'b100001, 6'b100000, 6'b100100, 6'b001100,
                   6'b000011, 6'b001111, 6'b001110, 6'b000110, 6'b001010,
                   6'b001011, 6'b000111, 6'b100101, 6'b101001, 6'b101000};
        fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                   6'b101010, 6'b001000, 6'b001001, 6'b011000};
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mnem      = '0;
        rs        = '0;
        rt        = '0;
        rd        = '0;
        shamt     = '0;
        imm       = '0;
        target    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'd0);
        chk(in_ready == 1'b1, "rst_in_ready", 32'(in_ready), 32'd1);
        chk(illegal == 1'b0, "rst_illegal", 32'(illegal), 32'd0);
        chk(instr == 32'd0, "rst_instr", instr, 32'd0);

        out_ready = 1'b1;
        send(0, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0, 1'b1, 32'h00221820);
        idle(2);
        send(8, 5'd29, 5'd9, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b1, 32'h8FA90004);
        send(14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000, 1'b1, 32'h08100000);
        send(5, 5'd31, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b1, 32'h03E00008);
        send(11, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b1, 32'h20080005);
        idle(2);

        out_ready = 1'b0;
        send(1, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0);
        send(3, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0);
        set_in(13, 5'd10, 5'd11, 5'd0, 5'd0, 16'hBEEF, 26'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(g);
            chk(!g, "held_third", 32'(g), 32'd0);
        end
        chk(in_ready == 1'b0, "full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            g = 1'b0;
            while (!g && n < 20) begin
                step(g);
                n++;
            end
            chk(g, "third_accept", 32'(g), 32'd1);
        end
        drain();

        send(31, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0, 32'h0);
        idle(2);
`ifdef MIPS_ENC_STATS_EN
        chk(illegal_count == CNT_W'(exp_ill_cnt), "illegal_count",
            32'(illegal_count), 32'(exp_ill_cnt));
        chk(enc_count == CNT_W'(exp_enc_cnt), "enc_count",
            32'(enc_count), 32'(exp_enc_cnt));
`endif
        send(30, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0);
        send(31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0);
        send(21, 5'd9, 5'd3, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1, 32'h3C031234);
        idle(3);

        out_ready = 1'b0;
        send(2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0);
        send(4, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0);
        in_valid = 1'b0;
        reset    = 1'b1;
        step(g);
        reset = 1'b0;
        chk(out_valid == 1'b0, "mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk(in_ready == 1'b1, "mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk(instr == 32'd0, "mid_rst_instr", instr, 32'd0);
        out_ready = 1'b1;
        idle(4);

        rnd_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle(1);
            end else begin
                send(int'($urandom_range(0, 31)), 5'($urandom), 5'($urandom),
                     5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom),
                     1'b0, 32'h0);
            end
        end
        drain();
`ifdef MIPS_ENC_STATS_EN
        chk(illegal_count == CNT_W'(exp_ill_cnt), "illegal_count_end",
            32'(illegal_count), 32'(exp_ill_cnt));
        chk(enc_count == CNT_W'(exp_enc_cnt), "enc_count_end",
            32'(enc_count), 32'(exp_enc_cnt));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Encoder counterpart to the main control decoder: converts a mnemonic ID plus register/immediate fields into a 32-bit MIPS instruction word.
- Used by the instruction-memory loader and the test harness to build imem contents in hardware.
- Valid/ready input, registered output behind a 2-entry skid FIFO.
- Every opcode/funct pair the decoder recognises is encodable.

Parameters:
- DEPTH, 2, output buffer entries (power of two, >=2)
- CNT_W, 16, width of statistics counters (optional feature only)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept
- mnem  in  5  mnemonic ID (see Behaviour)
- rs  in  5  source register
- rt  in  5  target register
- rd  in  5  destination register
- shamt  in  5  shift amount
- imm  in  16  immediate / branch offset
- target  in  26  jump target field
- out_valid  out  1  instr valid
- out_ready  in  1  consumer accepts
- instr  out  32  encoded instruction
- illegal  out  1  one-cycle pulse: accepted request had an unknown mnem

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: FIFO empty, out_valid=0, instr=0, illegal=0, in_ready=1 in the cycle after reset deasserts. Reset mid-transfer discards all buffered words.
- Accept and dequeue conditions:
  - Accept occurs when in_valid&&in_ready.
  - in_ready = !full. It is combinational from FIFO state only, never from out_ready.
  - Dequeue occurs when out_valid&&out_ready.
  - Simultaneous accept and dequeue when full is not allowed; in_ready is 0 in that case.
  - Simultaneous accept and dequeue in any other state is legal, and the count is unchanged.
- Latency: an accepted legal request appears on instr with out_valid=1 on the next clock edge, provided the FIFO was empty. Order is strict FIFO.
- instr and out_valid are registered outputs, stable while out_valid&&!out_ready.
- Mnemonic IDs, 0..29 (op/funct in binary):
  - R-type, op 000000:
    - 0 ADD, funct 100000
    - 1 SUB, funct 100010
    - 2 AND, funct 100100
    - 3 OR, funct 100101
    - 4 SLT, funct 101010
    - 5 JR, funct 001000
    - 6 JALR, funct 001001
    - 7 MULT, funct 011000
  - I-type:
    - 8 LW 100011, 9 SW 101011, 10 BEQ 000100, 11 ADDI 001000
    - 12 ADDIU 001001, 13 ORI 001101, 15 BNE 000101, 16 LH 100001
    - 17 LB 100000, 18 LBU 100100, 19 ANDI 001100, 21 LUI 001111
    - 22 XORI 001110, 23 BLEZ 000110, 24 SLTI 001010, 25 SLTIU 001011
    - 26 BGTZ 000111, 27 LHU 100101, 28 SH 101001, 29 SB 101000
  - J-type: 14 J 000010, 20 JAL 000011
- Formats:
  - R: {000000,rs,rt,rd,shamt,funct}
  - I: {op,rs,rt,imm}
  - J: {op,target}
- Field forcing (inputs ignored, bits driven 0):
  - JR: rt, rd, shamt = 0
  - JALR: rt, shamt = 0
  - MULT: rd, shamt = 0
  - LUI: rs = 0
  - BLEZ, BGTZ: rt = 0
  - ADD/SUB/AND/OR/SLT: shamt = 0
- Illegal mnem (30, 31):
  - The request is still accepted (consumes the handshake).
  - Nothing is enqueued.
  - illegal=1 for exactly one cycle after acceptance.
  - Back-to-back illegal requests give illegal high for consecutive cycles.
- Implementation:
  - Encoding is a combinational case on mnem feeding the FIFO write port.
  - FIFO uses wrapping read/write pointers of log2(DEPTH) bits plus a count register of log2(DEPTH)+1 bits.

Optional Feature:
- Macro: MIPS_ENC_STATS_EN.
- When defined, adds output ports enc_count [CNT_W-1:0] and illegal_count [CNT_W-1:0].
  - enc_count increments on each legal accept.
  - illegal_count increments on each illegal accept.
  - Both saturate at all-ones (no wrap) and clear on reset.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- ADD rs=1 rt=2 rd=3 shamt=7, out_ready=1 -> next cycle instr=0x00221820 (shamt forced 0), out_valid=1 for 1 cycle.
- LW rs=29 rt=9 imm=0x0004, then J target=0x0100000, back-to-back -> instr=0x8FA90004, then 0x08100000, in order, one per cycle.
- JR rs=31 rt=5 rd=6 -> instr=0x03E00008; ADDI rs=0 rt=8 imm=5 -> 0x20080005.
- Backpressure: out_ready=0, offer 3 legal requests -> 2 accepted, in_ready=0, third held. Raise out_ready -> third accepted, outputs drain in order, instr stable while stalled.
- mnem=31 accepted -> illegal=1 for one cycle, out_valid stays 0. With MIPS_ENC_STATS_EN defined: illegal_count=1, enc_count=0.
- Fill FIFO with 2 words, assert reset for 1 cycle -> out_valid=0, in_ready=1 after reset, no stale word is ever emitted.
